hazard_scoreboard: RTL and testbench

Pipeline hazard detector for the 5-stage ARM core; the consumer of the decode stage's `src1`/`src2`/`Two_src` outputs and the producer of the `hazard` signal the decode stage uses to squash its control word. It tracks in-flight register writers in EXE and MEM in a small shift-register scoreboard. It raises `hazard` combinationally when a decoded source register depends on a pending write, and counts stall cycles for performance analysis.

---
 rtl/arm_pipe_pkg.sv | 16 +
 rtl/hazard_match.sv | 23 ++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types for the 5-stage ARM core: register address width,
// the hazard scoreboard slot record and its empty value.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  // One in-flight register writer: slot occupied, writer is a load, destination register.
  typedef struct packed {
    logic             valid;
    logic             load;
    logic [REG_W-1:0] dest;
  } sb_slot_t;

  localparam sb_slot_t SB_SLOT_EMPTY = '{valid: 1'b0, load: 1'b0, dest: '0};

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does one scoreboard slot produce a register the
// instruction in ID reads? Also reports whether that producer is a load.
module hazard_match
  import arm_pipe_pkg::*;
(
  input  sb_slot_t         i_slot,
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_two_src,
  output logic             o_match,
  output logic             o_load_match
);

  logic w_src1_hit;
  logic w_src2_hit;

  // src1 is always a real operand; src2 only counts when ID says so.
  assign w_src1_hit   = i_slot.valid && (i_slot.dest == i_src1);
  assign w_src2_hit   = i_slot.valid && i_two_src && (i_slot.dest == i_src2);
  assign o_match      = w_src1_hit || w_src2_hit;
  assign o_load_match = o_match && i_slot.load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard detector. Tracks register writers in EXE and MEM, raises
// hazard combinationally on a RAW dependency of the instruction in ID, and
// keeps a saturating count of stall cycles.
// Optional feature macro: HAZARD_FORWARDING_EN -- when defined, EXE/MEM
// forwarding exists downstream and only a load in EXE (load-use) stalls.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = arm_pipe_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             flush,
  input  logic             freeze,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_count,
  output logic             exe_busy,
  output logic             mem_busy
);

  sb_slot_t         r_exe;
  sb_slot_t         r_mem;
  logic [CNT_W-1:0] r_stall_count;

  sb_slot_t w_id_slot;
  logic     w_exe_match;
  logic     w_exe_load_match;
  logic     w_mem_match;
  logic     w_mem_load_match;
  logic     w_hazard;
  logic     w_cnt_full;
  logic     w_unused;

  hazard_match u_exe_match (
    .i_slot       (r_exe),
    .i_src1       (src1),
    .i_src2       (src2),
    .i_two_src    (two_src),
    .o_match      (w_exe_match),
    .o_load_match (w_exe_load_match)
  );

  hazard_match u_mem_match (
    .i_slot       (r_mem),
    .i_src1       (src1),
    .i_src2       (src2),
    .i_two_src    (two_src),
    .o_match      (w_mem_match),
    .o_load_match (w_mem_load_match)
  );

  // Writer currently in ID, as it would be recorded in the EXE slot.
  assign w_id_slot = '{valid: id_wb_en, load: id_mem_r_en, dest: id_dest};

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results from EXE and anything in MEM; only a
  // load still in EXE has no data yet.
  assign w_hazard = w_exe_load_match;
  assign w_unused = ^{w_exe_match, w_mem_match, w_mem_load_match};
`else
  // No forwarding: any pending writer of a checked source stalls.
  assign w_hazard = w_exe_match || w_mem_match;
  assign w_unused = ^{w_exe_load_match, w_mem_load_match};
`endif

  assign w_cnt_full = &r_stall_count;

  // Scoreboard shift and stall counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; r_mem <= r_exe must see the old EXE slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the async reset clears the slots themselves, so hazard drops
      // the moment reset asserts without waiting for a clock.
      r_exe         <= SB_SLOT_EMPTY;
      r_mem         <= SB_SLOT_EMPTY;
      r_stall_count <= '0;
    end else if (!freeze) begin
      r_mem <= r_exe;
      r_exe <= (w_hazard || flush) ? SB_SLOT_EMPTY : w_id_slot;
      if (w_hazard && !w_cnt_full) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end else if (flush) begin
      // Pipeline held, but the squashed instruction must not linger in EXE.
      r_exe.valid <= 1'b0;
    end
  end

  assign hazard      = w_hazard;
  assign stall_count = r_stall_count;
  assign exe_busy    = r_exe.valid;
  assign mem_busy    = r_mem.valid;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push hand-computed
// expectations into a queue; a negedge monitor pops and compares. A second
// instance with a 2-bit counter exercises stall-count saturation.
// Honours HAZARD_FORWARDING_EN for its expected values.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src1, src2, id_dest;
  logic        two_src, id_wb_en, id_mem_r_en, flush, freeze;
  logic        hazard, exe_busy, mem_busy;
  logic [31:0] stall_count;
  logic        sat_hazard, sat_exe_busy, sat_mem_busy;
  logic [1:0]  sat_count;

  typedef struct {
    string name;
    int    haz;
    int    cnt;
    int    exe;
    int    mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .flush(flush), .freeze(freeze), .hazard(hazard), .stall_count(stall_count),
    .exe_busy(exe_busy), .mem_busy(mem_busy)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .flush(flush), .freeze(freeze), .hazard(sat_hazard), .stall_count(sat_count),
    .exe_busy(sat_exe_busy), .mem_busy(sat_mem_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Pick the expected value for the build under test.
  function automatic int c(input int no_fwd, input int fwd);
    return FWD ? fwd : no_fwd;
  endfunction

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      check({e.name, ".hazard"},      32'(hazard),       e.haz);
      check({e.name, ".stall_count"}, stall_count,       e.cnt);
      check({e.name, ".exe_busy"},    32'(exe_busy),     e.exe);
      check({e.name, ".mem_busy"},    32'(mem_busy),     e.mem);
      check({e.name, ".sat_hazard"},  32'(sat_hazard),   e.haz);
      check({e.name, ".sat_count"},   32'(sat_count),    (e.cnt > 3) ? 3 : e.cnt);
    end
  end

  // Drive one ID-stage vector after the edge and queue its expected response.
  task automatic step(input string name, input int s1, input int s2, input int two,
                      input int wb, input int ld, input int dest, input int fl,
                      input int fz, input int eh, input int ec, input int ee,
                      input int em);
    @(posedge clk);
    #1;
    src1        = 4'(s1);
    src2        = 4'(s2);
    two_src     = 1'(two);
    id_wb_en    = 1'(wb);
    id_mem_r_en = 1'(ld);
    id_dest     = 4'(dest);
    flush       = 1'(fl);
    freeze      = 1'(fz);
    exp_q.push_back('{name, eh, ec, ee, em});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    src1 = '0; src2 = '0; id_dest = '0;
    two_src = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; flush = 1'b0; freeze = 1'b0;

    // Reset held with random inputs: nothing may be recorded or counted.
    for (int i = 0; i < 4; i++) begin
      step("rst_rand", int'($urandom_range(15)), int'($urandom_range(15)),
           int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
           int'($urandom_range(15)), int'($urandom_range(1)), int'($urandom_range(1)),
           0, 0, 0, 0);
    end
    step("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    //    name          s1 s2 2s wb ld dst fl fz  haz        count      exe mem
    step("idle0",       0, 0, 0, 0, 0, 0, 0, 0, 0,         0,         0, 0);
    // RAW on an ALU result.
    step("raw_wr",      0, 0, 0, 1, 0, 3, 0, 0, 0,         0,         0, 0);
    step("raw_s1",      3, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   0,         1, 0);
    step("raw_s2",      3, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   c(1, 0),   0, 1);
    step("raw_go",      3, 0, 0, 0, 0, 0, 0, 0, 0,         c(2, 0),   0, 0);
    // Store data operand on src2, two_src=1.
    step("st_wr",       0, 0, 0, 1, 0, 5, 0, 0, 0,         c(2, 0),   0, 0);
    step("st_dep",      1, 5, 1, 0, 0, 0, 0, 0, c(1, 0),   c(2, 0),   1, 0);
    step("st_dep2",     1, 5, 1, 0, 0, 0, 0, 0, c(1, 0),   c(3, 0),   0, 1);
    step("st_go",       1, 5, 1, 0, 0, 0, 0, 0, 0,         c(4, 0),   0, 0);
    // Same sequence with two_src=0: src2 ignored.
    step("st1_wr",      0, 0, 0, 1, 0, 5, 0, 0, 0,         c(4, 0),   0, 0);
    step("st1_nodep",   1, 5, 0, 0, 0, 0, 0, 0, 0,         c(4, 0),   1, 0);
    step("st1_nodep2",  1, 5, 0, 0, 0, 0, 0, 0, 0,         c(4, 0),   0, 1);
    // Load-use.
    step("ld_wr",       0, 0, 0, 1, 1, 2, 0, 0, 0,         c(4, 0),   0, 0);
    step("ld_use",      2, 0, 0, 0, 0, 0, 0, 0, 1,         c(4, 0),   1, 0);
    step("ld_use2",     2, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   c(5, 1),   0, 1);
    step("ld_go",       2, 0, 0, 0, 0, 0, 0, 0, 0,         c(6, 1),   0, 0);
    // ALU writer of R2 then dependent.
    step("alu_wr",      0, 0, 0, 1, 0, 2, 0, 0, 0,         c(6, 1),   0, 0);
    step("alu_use",     2, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   c(6, 1),   1, 0);
    step("alu_use2",    2, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   c(7, 1),   0, 1);
    step("alu_go",      2, 0, 0, 0, 0, 0, 0, 0, 0,         c(8, 1),   0, 0);
    // Flushed writer never enters EXE.
    step("fl_wr",       0, 0, 0, 1, 0, 7, 1, 0, 0,         c(8, 1),   0, 0);
    step("fl_use",      7, 0, 0, 0, 0, 0, 0, 0, 0,         c(8, 1),   0, 0);
    // Freeze during a load-use stall: slots and count hold.
    step("fz_wr",       0, 0, 0, 1, 1, 4, 0, 0, 0,         c(8, 1),   0, 0);
    for (int i = 0; i < 3; i++) begin
      step("fz_hold",   4, 0, 0, 0, 0, 0, 0, 1, 1,         c(8, 1),   1, 0);
    end
    step("fz_rel",      4, 0, 0, 0, 0, 0, 0, 0, 1,         c(8, 1),   1, 0);
    step("fz_mem",      4, 0, 0, 0, 0, 0, 0, 0, c(1, 0),   c(9, 2),   0, 1);
    step("fz_go",       4, 0, 0, 0, 0, 0, 0, 0, 0,         c(10, 2),  0, 0);
    // Flush during freeze clears EXE while MEM holds.
    step("ff_wr",       0, 0, 0, 1, 0, 6, 0, 0, 0,         c(10, 2),  0, 0);
    step("ff_adv",      0, 0, 0, 1, 0, 8, 0, 0, 0,         c(10, 2),  1, 0);
    step("ff_frz",      0, 0, 0, 0, 0, 0, 1, 1, 0,         c(10, 2),  1, 1);
    step("ff_chk",      6, 0, 0, 0, 0, 0, 0, 1, c(1, 0),   c(10, 2),  0, 1);
    step("ff_rel",      0, 0, 0, 0, 0, 0, 0, 0, 0,         c(10, 2),  0, 1);
    step("ff_go",       0, 0, 0, 0, 0, 0, 0, 0, 0,         c(10, 2),  0, 0);
    // Reset asserted mid-stall.
    step("rs_wr",       0, 0, 0, 1, 1, 9, 0, 0, 0,         c(10, 2),  0, 0);
    step("rs_use",      9, 0, 0, 0, 0, 0, 0, 0, 1,         c(10, 2),  1, 0);
    #6;
    rst = 1'b0;
    #1;
    n_vec++;
    check("rst_async.hazard",      32'(hazard),   0);
    check("rst_async.exe_busy",    32'(exe_busy), 0);
    check("rst_async.stall_count", stall_count,   0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0,         0,         0, 0);
    step("post_use",    9, 0, 0, 0, 0, 0, 0, 0, 0,         0,         0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
